// File: rtl/hazard_forward_unit.sv
// Pipeline hazard controller: multi-operand forwarding, load-use interlock,
// multi-cycle EX stall sequencing, taken-branch flush and perf counters.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no multi-cycle op in flight; branch flush / load-use evaluated
// BUSY  | multi-cycle op occupying EX; stalls until cnt reaches zero
module hazard_forward_unit #(
    parameter int NUM_REGS   = 32,
    parameter int REG_SEL    = $clog2(NUM_REGS),
    parameter int NUM_SRC    = 2,
    parameter int MC_LATENCY = 4,
    parameter int PERF_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*REG_SEL-1:0] id_rs,
    input  logic [NUM_SRC-1:0]         id_rs_used,
    input  logic [NUM_SRC*REG_SEL-1:0] ex_rs,
    input  logic [REG_SEL-1:0]         ex_rd,
    input  logic                       ex_mem_read,
    input  logic                       ex_mc_start,
    input  logic                       ex_branch_taken,
    input  logic [REG_SEL-1:0]         mem_rd,
    input  logic                       mem_reg_write,
    input  logic [REG_SEL-1:0]         wb_rd,
    input  logic                       wb_reg_write,
    input  logic                       perf_clr,
    output logic [2*NUM_SRC-1:0]       fwd_sel,
    output logic                       stall_if,
    output logic                       stall_id,
    output logic                       stall_ex,
    output logic                       bubble_ex,
    output logic                       bubble_mem,
    output logic                       flush_if,
    output logic                       flush_id,
    output logic                       mc_busy,
    output logic [PERF_W-1:0]          perf_stall_cnt,
    output logic [PERF_W-1:0]          perf_flush_cnt
);

    localparam int CNT_W = $clog2(MC_LATENCY) + 1;
    localparam bit MC_ENABLED = (MC_LATENCY > 1);
    // First stall cycle happens in IDLE, so BUSY only needs MC_LATENCY-2 more.
    localparam logic [CNT_W-1:0] CNT_LOAD = MC_ENABLED ? CNT_W'(MC_LATENCY - 2) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lu_match;
    logic               mc_start_now;
    logic               mc_stall;
    logic               branch_flush;
    logic               load_use;

    assign mc_start_now = (state == IDLE) && ex_mc_start && MC_ENABLED;
    assign mc_stall     = mc_start_now || ((state == BUSY) && (cnt != '0));
    assign branch_flush = (state == IDLE) && !mc_start_now && ex_branch_taken;
    assign load_use     = (state == IDLE) && !mc_start_now && !ex_branch_taken &&
                          ex_mem_read && (ex_rd != '0) && lu_match;

    // Per-operand bypass select; MEM result is newer so it wins over WB.
    always_comb begin
        fwd_sel = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (mem_reg_write && (mem_rd != '0) &&
                    (mem_rd == ex_rs[i*REG_SEL +: REG_SEL])) begin
                    fwd_sel[2*i +: 2] = 2'b10;
                end else if (wb_reg_write && (wb_rd != '0) &&
                             (wb_rd == ex_rs[i*REG_SEL +: REG_SEL])) begin
                    fwd_sel[2*i +: 2] = 2'b01;
                end
            end
        end
    end

    // Does any actually-read ID operand name the load destination?
    always_comb begin
        lu_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (id_rs[i*REG_SEL +: REG_SEL] == ex_rd)) begin
                lu_match = 1'b1;
            end
        end
    end

    // Pipeline control outputs, all masked while reset is held.
    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        mc_busy    = 1'b0;
        if (!rst) begin
            stall_if   = mc_stall || load_use;
            stall_id   = mc_stall || load_use;
            stall_ex   = mc_stall;
            bubble_mem = mc_stall;
            bubble_ex  = load_use;
            flush_if   = branch_flush;
            flush_id   = branch_flush;
            mc_busy    = (state == BUSY);
        end
    end

    // Multi-cycle op sequencer; ex_mc_start is ignored on the release cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mc_start_now) begin
                        cnt   <= CNT_LOAD;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Saturating stall-cycle counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_stall_cnt <= '0;
        end else if (stall_if && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
        end
    end

    // Saturating flush-cycle counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_flush_cnt <= '0;
        end else if (flush_if && (perf_flush_cnt != '1)) begin
            perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a 3-operand, 4-cycle, 4-bit-counter
// instance plus a 2-operand MC_LATENCY=1 instance sharing clock and controls.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] id_rs;
    logic [2:0]  id_rs_used;
    logic [14:0] ex_rs;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_mc_start;
    logic        ex_branch_taken;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        perf_clr;

    logic [5:0]  fwd_sel;
    logic        stall_if, stall_id, stall_ex, bubble_ex, bubble_mem;
    logic        flush_if, flush_id, mc_busy;
    logic [3:0]  perf_stall_cnt, perf_flush_cnt;

    logic [9:0]  id_rs1 = '0;
    logic [1:0]  id_rs_used1 = '0;
    logic [9:0]  ex_rs1 = '0;
    logic [3:0]  fwd_sel1;
    logic        stall_if1, stall_id1, stall_ex1, bubble_ex1, bubble_mem1;
    logic        flush_if1, flush_id1, mc_busy1;
    logic [7:0]  perf_stall_cnt1, perf_flush_cnt1;

    logic [7:0]  ctrl;
    assign ctrl = {stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_if, flush_id, mc_busy};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.NUM_REGS(32), .NUM_SRC(3), .MC_LATENCY(4), .PERF_W(4)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start),
        .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .perf_clr(perf_clr), .fwd_sel(fwd_sel),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
        .bubble_mem(bubble_mem), .flush_if(flush_if), .flush_id(flush_id), .mc_busy(mc_busy),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    hazard_forward_unit #(.NUM_REGS(32), .NUM_SRC(2), .MC_LATENCY(1), .PERF_W(8)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs1), .id_rs_used(id_rs_used1), .ex_rs(ex_rs1),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start),
        .ex_branch_taken(1'b0), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .perf_clr(perf_clr), .fwd_sel(fwd_sel1),
        .stall_if(stall_if1), .stall_id(stall_id1), .stall_ex(stall_ex1), .bubble_ex(bubble_ex1),
        .bubble_mem(bubble_mem1), .flush_if(flush_if1), .flush_id(flush_id1), .mc_busy(mc_busy1),
        .perf_stall_cnt(perf_stall_cnt1), .perf_flush_cnt(perf_flush_cnt1)
    );

    task automatic clear_inputs();
        id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rd = '0;
        ex_mem_read = 1'b0; ex_mc_start = 1'b0; ex_branch_taken = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
        perf_clr = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd7;
        id_rs = {5'd0, 5'd7, 5'd0}; id_rs_used = 3'b010;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        set_load_use();
        ex_mc_start = 1'b1; ex_branch_taken = 1'b1;
        ex_rs = {5'd5, 5'd5, 5'd5}; mem_rd = 5'd5; mem_reg_write = 1'b1;
        #1;
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL reset_ctrl: got %h want %h", ctrl, 8'h00); end
        total++; if (fwd_sel !== 6'b0) begin bad++; $display("FAIL reset_fwd: got %b want %b", fwd_sel, 6'b0); end
        total++; if ({perf_stall_cnt, perf_flush_cnt} !== 8'h00) begin bad++; $display("FAIL reset_perf: got %h want %h", {perf_stall_cnt, perf_flush_cnt}, 8'h00); end
        total++; if ({stall_if1, mc_busy1, fwd_sel1} !== 6'b0) begin bad++; $display("FAIL reset_dut1: got %b want %b", {stall_if1, mc_busy1, fwd_sel1}, 6'b0); end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL reset_release_idle: got %h want %h", ctrl, 8'h00); end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        clear_inputs();
        ex_rs = {5'd5, 5'd5, 5'd0};
        mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
        #1;
        total++; if (fwd_sel !== 6'b101000) begin bad++; $display("FAIL fwd_mem_over_wb: got %b want %b", fwd_sel, 6'b101000); end
        mem_reg_write = 1'b0;
        #1;
        total++; if (fwd_sel !== 6'b010100) begin bad++; $display("FAIL fwd_wb_only: got %b want %b", fwd_sel, 6'b010100); end
        mem_rd = 5'd0; mem_reg_write = 1'b1;
        #1;
        total++; if (fwd_sel !== 6'b010100) begin bad++; $display("FAIL fwd_mem_x0_no_block: got %b want %b", fwd_sel, 6'b010100); end
        mem_rd = 5'd3; ex_rs = {5'd3, 5'd5, 5'd9};
        #1;
        total++; if (fwd_sel !== 6'b100100) begin bad++; $display("FAIL fwd_mixed: got %b want %b", fwd_sel, 6'b100100); end
        wb_reg_write = 1'b0; mem_reg_write = 1'b0;
        #1;
        total++; if (fwd_sel !== 6'b000000) begin bad++; $display("FAIL fwd_none: got %b want %b", fwd_sel, 6'b000000); end
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL fwd_no_ctrl: got %h want %h", ctrl, 8'h00); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        set_load_use();
        #1;
        total++; if (ctrl !== 8'hD0) begin bad++; $display("FAIL lu_op1: got %h want %h", ctrl, 8'hD0); end
        id_rs = {5'd7, 5'd0, 5'd0}; id_rs_used = 3'b100;
        #1;
        total++; if (ctrl !== 8'hD0) begin bad++; $display("FAIL lu_op2: got %h want %h", ctrl, 8'hD0); end
        id_rs = {5'd0, 5'd7, 5'd0}; id_rs_used = 3'b000;
        #1;
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL lu_unused: got %h want %h", ctrl, 8'h00); end
        ex_rd = 5'd0; id_rs = '0; id_rs_used = 3'b111;
        #1;
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL lu_x0: got %h want %h", ctrl, 8'h00); end
        set_load_use(); ex_mem_read = 1'b0;
        #1;
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL lu_not_load: got %h want %h", ctrl, 8'h00); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL lu_one_cycle: got %h want %h", ctrl, 8'h00); end
    endtask

    task automatic run_mc(input int cycles, input logic branch, input string name);
        logic [7:0] exp;
        int k;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            clear_inputs();
            ex_mc_start = 1'b1; ex_branch_taken = branch;
            #1;
            k = (c - 1) % 4 + 1;
            exp = (k == 1) ? 8'hE8 : (k < 4) ? 8'hE9 : 8'h01;
            total++; if (ctrl !== exp) begin bad++; $display("FAIL %s_cyc%0d: got %h want %h", name, c, ctrl, exp); end
            total++; if ({stall_if1, stall_ex1, bubble_mem1, mc_busy1} !== 4'b0) begin bad++; $display("FAIL %s_lat1_cyc%0d: got %b want %b", name, c, {stall_if1, stall_ex1, bubble_mem1, mc_busy1}, 4'b0); end
        end
    endtask

    task automatic test_multicycle();
        @(negedge clk);
        clear_inputs(); perf_clr = 1'b1;
        run_mc(4, 1'b0, "mc");
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL mc_done_idle: got %h want %h", ctrl, 8'h00); end
        total++; if (perf_stall_cnt !== 4'd3) begin bad++; $display("FAIL mc_perf_stall: got %0d want %0d", perf_stall_cnt, 3); end
        total++; if (perf_stall_cnt1 !== 8'd0) begin bad++; $display("FAIL mc_lat1_perf: got %0d want %0d", perf_stall_cnt1, 0); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        clear_inputs(); perf_clr = 1'b1;
        run_mc(8, 1'b0, "b2b");
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL b2b_idle: got %h want %h", ctrl, 8'h00); end
        total++; if (perf_stall_cnt !== 4'd6) begin bad++; $display("FAIL b2b_perf: got %0d want %0d", perf_stall_cnt, 6); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        clear_inputs(); perf_clr = 1'b1;
        @(negedge clk);
        clear_inputs();
        set_load_use(); ex_branch_taken = 1'b1;
        #1;
        total++; if (ctrl !== 8'h06) begin bad++; $display("FAIL br_over_lu: got %h want %h", ctrl, 8'h06); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (perf_flush_cnt !== 4'd1) begin bad++; $display("FAIL br_perf_flush: got %0d want %0d", perf_flush_cnt, 1); end
        total++; if (perf_stall_cnt !== 4'd0) begin bad++; $display("FAIL br_perf_stall: got %0d want %0d", perf_stall_cnt, 0); end
        run_mc(4, 1'b1, "br_busy");
        @(negedge clk);
        clear_inputs(); ex_branch_taken = 1'b1;
        #1;
        total++; if (ctrl !== 8'h06) begin bad++; $display("FAIL br_after_busy: got %h want %h", ctrl, 8'h06); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (perf_flush_cnt !== 4'd2) begin bad++; $display("FAIL br_perf_flush2: got %0d want %0d", perf_flush_cnt, 2); end
        total++; if (perf_stall_cnt !== 4'd3) begin bad++; $display("FAIL br_perf_stall2: got %0d want %0d", perf_stall_cnt, 3); end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        clear_inputs(); ex_mc_start = 1'b1;
        #1;
        total++; if (ctrl !== 8'hE8) begin bad++; $display("FAIL rmb_start: got %h want %h", ctrl, 8'hE8); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL rmb_during_rst: got %h want %h", ctrl, 8'h00); end
        @(negedge clk);
        rst = 1'b0; ex_mc_start = 1'b0;
        #1;
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL rmb_after_rst: got %h want %h", ctrl, 8'h00); end
        total++; if ({perf_stall_cnt, perf_flush_cnt} !== 8'h00) begin bad++; $display("FAIL rmb_perf: got %h want %h", {perf_stall_cnt, perf_flush_cnt}, 8'h00); end
        @(negedge clk);
        #1;
        total++; if (ctrl !== 8'h00) begin bad++; $display("FAIL rmb_stays_idle: got %h want %h", ctrl, 8'h00); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        clear_inputs(); perf_clr = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            clear_inputs();
            set_load_use();
        end
        @(negedge clk);
        clear_inputs();
        set_load_use(); perf_clr = 1'b1;
        #1;
        total++; if (perf_stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_stall: got %0d want %0d", perf_stall_cnt, 15); end
        @(negedge clk);
        perf_clr = 1'b0;
        #1;
        total++; if (perf_stall_cnt !== 4'd0) begin bad++; $display("FAIL sat_clr_wins: got %0d want %0d", perf_stall_cnt, 0); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (perf_stall_cnt !== 4'd1) begin bad++; $display("FAIL sat_restart: got %0d want %0d", perf_stall_cnt, 1); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_multicycle();
        test_back_to_back();
        test_branch();
        test_reset_mid_busy();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
